// File: rtl/toy_bus_pkg.sv
// rtl/toy_bus_pkg.sv - shared widths, opcodes and node ids for the toy_bus network
package toy_bus_pkg;

  localparam int ID_W      = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int OST_DEPTH = 4;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam logic [ID_W-1:0] NODE_ID_CORE0  = 4'd0;
  localparam logic [ID_W-1:0] NODE_ID_SLV_EP = 4'd2;

endpackage

// File: rtl/toy_bus_id_fifo.sv
// rtl/toy_bus_id_fifo.sv - in-order tracker of outstanding {src_id, opcode} entries
module toy_bus_id_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Payload storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/toy_bus_slv_endpoint.sv
// rtl/toy_bus_slv_endpoint.sv - toy_bus target endpoint; TOY_BUS_EP_ERR_CHK_EN adds err_sticky/err_cnt
module toy_bus_slv_endpoint #(
  parameter int                NODE_ID_W = toy_bus_pkg::ID_W,
  parameter logic [NODE_ID_W-1:0] NODE_ID = toy_bus_pkg::NODE_ID_SLV_EP,
  parameter int                OST_DEPTH = toy_bus_pkg::OST_DEPTH,
  parameter int                ADDR_W    = toy_bus_pkg::ADDR_W,
  parameter int                DATA_W    = toy_bus_pkg::DATA_W,
  parameter int                ID_W      = NODE_ID_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in0_req_vld,
  output logic                in0_req_rdy,
  input  logic [ADDR_W-1:0]   in0_req_addr,
  input  logic [DATA_W-1:0]   in0_req_data,
  input  logic [DATA_W/8-1:0] in0_req_strb,
  input  logic                in0_req_opcode,
  input  logic [ID_W-1:0]     in0_req_src_id,
  input  logic [ID_W-1:0]     in0_req_tgt_id,
  output logic                in0_ack_vld,
  input  logic                in0_ack_rdy,
  output logic                in0_ack_opcode,
  output logic [DATA_W-1:0]   in0_ack_data,
  output logic [ID_W-1:0]     in0_ack_src_id,
  output logic [ID_W-1:0]     in0_ack_tgt_id,
  output logic                slv_req_vld,
  input  logic                slv_req_rdy,
  output logic [ADDR_W-1:0]   slv_req_addr,
  output logic [DATA_W-1:0]   slv_req_data,
  output logic [DATA_W/8-1:0] slv_req_strb,
  output logic                slv_req_opcode,
  input  logic                slv_ack_vld,
  output logic                slv_ack_rdy,
  input  logic [DATA_W-1:0]   slv_ack_data
`ifdef TOY_BUS_EP_ERR_CHK_EN
 ,output logic                err_sticky
 ,output logic [7:0]          err_cnt
`endif
);

  import toy_bus_pkg::*;

  logic          ost_full;
  logic          ost_empty;
  logic          push;
  logic          pop;
  logic [ID_W:0] head;

  assign slv_req_vld    = in0_req_vld & ~ost_full;
  assign in0_req_rdy    = slv_req_rdy & ~ost_full;
  assign slv_req_addr   = in0_req_addr;
  assign slv_req_data   = in0_req_data;
  assign slv_req_strb   = in0_req_strb;
  assign slv_req_opcode = in0_req_opcode;

  assign push        = slv_req_vld & slv_req_rdy;
  // A slave ack is taken only when it has an owner and the ack register can take it this cycle.
  assign slv_ack_rdy = ~ost_empty & (~in0_ack_vld | in0_ack_rdy);
  assign pop         = slv_ack_vld & slv_ack_rdy;

  toy_bus_id_fifo #(
    .W     (ID_W + 1),
    .DEPTH (OST_DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({in0_req_src_id, in0_req_opcode}),
    .pop       (pop),
    .head      (head),
    .full      (ost_full),
    .empty     (ost_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in0_ack_vld    <= 1'b0;
      in0_ack_opcode <= OP_RD;
      in0_ack_data   <= '0;
      in0_ack_src_id <= '0;
      in0_ack_tgt_id <= '0;
    end else if (pop) begin
      in0_ack_vld    <= 1'b1;
      in0_ack_opcode <= head[0];
      in0_ack_data   <= slv_ack_data;
      in0_ack_src_id <= NODE_ID;
      in0_ack_tgt_id <= head[ID_W:1];
    end else if (in0_ack_rdy) begin
      in0_ack_vld <= 1'b0;
    end
  end

`ifdef TOY_BUS_EP_ERR_CHK_EN
  logic       req_err;
  logic       ack_err;
  logic [8:0] cnt_sum;

  // Both event kinds can land in one cycle, so the counter may step by two.
  assign req_err = push & (in0_req_tgt_id != NODE_ID);
  assign ack_err = slv_ack_vld & ost_empty;
  assign cnt_sum = {1'b0, err_cnt} + {8'd0, req_err} + {8'd0, ack_err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      err_sticky <= err_sticky | req_err | ack_err;
      err_cnt    <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    end
  end
`else
  logic unused_tgt_id;
  assign unused_tgt_id = ^in0_req_tgt_id;
`endif

endmodule
